// File: rtl/uart_tx_param_if.sv
// Word handshake between the byte source (CPU/FIFO) and the UART transmitter.
// master = source driving DIN/DIN_VALID, slave = transmitter driving DIN_READY.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;

  modport master (output DIN, output DIN_VALID, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an internal bit-rate divider.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Optional feature macro: UART_TX_PARITY_EN (compiles in the PARITY state and
// parity register; PARITY_ODD selects odd parity).
//
// state  | meaning
// IDLE   | line high, DIN_READY asserted, waiting for a word
// START  | driving the start bit (0)
// DATA   | driving shreg[0], shifting right at each bit end
// PARITY | driving the latched parity bit (UART_TX_PARITY_EN only)
// STOP   | driving stop bit(s) (1), bit_idx counts stop bits
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 CLR,
  uart_tx_param_if.slave       bus,
  output logic                 SERIAL_OUT,
  output logic                 BUSY,
  output logic                 TX_DONE
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                bit_end;

`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`else
  // Odd/even selection has no meaning without the parity bit.
  logic                unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Ready is combinational so a word can be taken in the TX_DONE cycle.
  assign bus.DIN_READY = (state == IDLE) && !CLR;

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      SERIAL_OUT <= 1'b1;
      BUSY       <= 1'b0;
      TX_DONE    <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;
      if (state == IDLE) begin
        if (bus.DIN_VALID) begin
          shreg      <= bus.DIN;
`ifdef UART_TX_PARITY_EN
          parity_q   <= (PARITY_ODD != 0) ? ~^bus.DIN : ^bus.DIN;
`endif
          state      <= START;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          SERIAL_OUT <= 1'b0;
          BUSY       <= 1'b1;
        end
      end else begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
        if (bit_end) begin
          case (state)
            START: begin
              state      <= DATA;
              bit_idx    <= '0;
              SERIAL_OUT <= shreg[0];
            end
            DATA: begin
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                state      <= PARITY;
                SERIAL_OUT <= parity_q;
`else
                state      <= STOP;
                SERIAL_OUT <= 1'b1;
`endif
              end else begin
                shreg      <= shreg >> 1;
                SERIAL_OUT <= shreg[1];
                bit_idx    <= bit_idx + IDX_W'(1);
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state      <= STOP;
              bit_idx    <= '0;
              SERIAL_OUT <= 1'b1;
            end
`endif
            STOP: begin
              if (bit_idx == STOP_LAST) begin
                state      <= IDLE;
                bit_idx    <= '0;
                BUSY       <= 1'b0;
                TX_DONE    <= 1'b1;
                SERIAL_OUT <= 1'b1;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
            default: begin
              state      <= IDLE;
              SERIAL_OUT <= 1'b1;
              BUSY       <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param. Instance A: 8 data bits, 4 clk/bit,
// 1 stop. Instance B: 5 data bits, 2 clk/bit, 2 stop. With
// UART_TX_PARITY_EN, instance C adds odd parity on top of A's settings.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int P_A = 1;
  localparam logic [15:0] PAT_0B = 16'b0_1101_0000_1_1;
  localparam logic [15:0] PAT_55 = 16'b0_1010_1010_0_1;
  localparam logic [15:0] PAT_A3 = 16'b0_1100_0101_0_1;
  localparam logic [15:0] PAT_0B_ODD = 16'b0_1101_0000_0_1;
`else
  localparam int P_A = 0;
  localparam logic [15:0] PAT_0B = 16'b0_1101_0000_1;
  localparam logic [15:0] PAT_55 = 16'b0_1010_1010_1;
  localparam logic [15:0] PAT_A3 = 16'b0_1100_0101_1;
`endif
  localparam logic [15:0] PAT_11 = 16'b0_10001_11;

  localparam int BITS_A = 10 + P_A;
  localparam int N_A    = BITS_A * 4;
  localparam int N_B    = 16;

  logic CLK;
  logic clr_a, clr_b;
  logic ser_a, busy_a, done_a;
  logic ser_b, busy_b, done_b;
  int   tests = 0;
  int   fails = 0;

  uart_tx_param_if #(.DATA_W(8)) bus_a ();
  uart_tx_param_if #(.DATA_W(5)) bus_b ();

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .CLK(CLK), .CLR(clr_a), .bus(bus_a.slave),
    .SERIAL_OUT(ser_a), .BUSY(busy_a), .TX_DONE(done_a));

  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(2), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .CLK(CLK), .CLR(clr_b), .bus(bus_b.slave),
    .SERIAL_OUT(ser_b), .BUSY(busy_b), .TX_DONE(done_b));

`ifdef UART_TX_PARITY_EN
  logic clr_c, ser_c, busy_c, done_c;
  uart_tx_param_if #(.DATA_W(8)) bus_c ();
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
    .CLK(CLK), .CLR(clr_c), .bus(bus_c.slave),
    .SERIAL_OUT(ser_c), .BUSY(busy_c), .TX_DONE(done_c));
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Line-order frame pattern, MSB-first in pat: bit i of the frame.
  function automatic logic pat_bit(input logic [15:0] pat, input int nbits, input int i);
    return pat[nbits-1-i];
  endfunction

  task automatic test_reset;
    clr_a = 1'b1; clr_b = 1'b1;
    bus_a.DIN = 8'h0B; bus_a.DIN_VALID = 1'b1;
    bus_b.DIN = 5'h11; bus_b.DIN_VALID = 1'b1;
    tick; tick;
    tests++; if (ser_a !== 1'b1) begin fails++; $display("FAIL reset_ser_a got=%b exp=1", ser_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done_a got=%b exp=0", done_a); end
    tests++; if (bus_a.DIN_READY !== 1'b0) begin fails++; $display("FAIL reset_ready_a got=%b exp=0", bus_a.DIN_READY); end
    tests++; if (ser_b !== 1'b1) begin fails++; $display("FAIL reset_ser_b got=%b exp=1", ser_b); end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy_b got=%b exp=0", busy_b); end
    bus_a.DIN_VALID = 1'b0; bus_b.DIN_VALID = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    #1;
    tests++; if (bus_a.DIN_READY !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", bus_a.DIN_READY); end
    tick;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_no_accept got=%b exp=0", busy_a); end
  endtask

  task automatic test_basic_frame;
    bus_a.DIN = 8'h0B; bus_a.DIN_VALID = 1'b1;
    tests++; if (bus_a.DIN_READY !== 1'b1) begin fails++; $display("FAIL basic_ready got=%b exp=1", bus_a.DIN_READY); end
    tick;
    bus_a.DIN_VALID = 1'b0;
    for (int c = 1; c <= N_A; c++) begin
      tests++; if (ser_a !== pat_bit(PAT_0B, BITS_A, (c-1)/4)) begin fails++;
        $display("FAIL basic_ser cyc=%0d got=%b exp=%b", c, ser_a, pat_bit(PAT_0B, BITS_A, (c-1)/4)); end
      tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_busy cyc=%0d got=%b exp=1", c, busy_a); end
      tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL basic_done_early cyc=%0d got=%b exp=0", c, done_a); end
      tick;
    end
    tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL basic_done got=%b exp=1", done_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy_end got=%b exp=0", busy_a); end
    tests++; if (bus_a.DIN_READY !== 1'b1) begin fails++; $display("FAIL basic_ready_end got=%b exp=1", bus_a.DIN_READY); end
    tests++; if (ser_a !== 1'b1) begin fails++; $display("FAIL basic_ser_end got=%b exp=1", ser_a); end
    tick;
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", done_a); end
  endtask

  task automatic test_busy_reject;
    bus_a.DIN = 8'h0B; bus_a.DIN_VALID = 1'b1;
    tick;
    bus_a.DIN_VALID = 1'b0;
    for (int c = 1; c <= N_A; c++) begin
      if (c == 6) begin bus_a.DIN = 8'hFF; bus_a.DIN_VALID = 1'b1; #1; end
      if (c == 16) begin bus_a.DIN_VALID = 1'b0; #1; end
      if (c >= 6 && c < 16) begin
        tests++; if (bus_a.DIN_READY !== 1'b0) begin fails++; $display("FAIL reject_ready cyc=%0d got=%b exp=0", c, bus_a.DIN_READY); end
      end
      tests++; if (ser_a !== pat_bit(PAT_0B, BITS_A, (c-1)/4)) begin fails++;
        $display("FAIL reject_ser cyc=%0d got=%b exp=%b", c, ser_a, pat_bit(PAT_0B, BITS_A, (c-1)/4)); end
      tick;
    end
    tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL reject_done got=%b exp=1", done_a); end
    tick;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reject_no_accept got=%b exp=0", busy_a); end
    bus_a.DIN = 8'h00;
  endtask

  task automatic test_back_to_back;
    logic e;
    bus_a.DIN = 8'h55; bus_a.DIN_VALID = 1'b1;
    tick;
    bus_a.DIN = 8'hA3;
    for (int c = 1; c <= 2*N_A + 1; c++) begin
      if (c == N_A + 2) bus_a.DIN_VALID = 1'b0;
      if (c <= N_A)          e = pat_bit(PAT_55, BITS_A, (c-1)/4);
      else if (c == N_A + 1) e = 1'b1;
      else                   e = pat_bit(PAT_A3, BITS_A, (c-N_A-2)/4);
      tests++; if (ser_a !== e) begin fails++; $display("FAIL b2b_ser cyc=%0d got=%b exp=%b", c, ser_a, e); end
      if (c == N_A + 1) begin
        tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL b2b_done1 got=%b exp=1", done_a); end
        tests++; if (bus_a.DIN_READY !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", bus_a.DIN_READY); end
      end
      if (c == N_A + 2) begin
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL b2b_busy2 got=%b exp=1", busy_a); end
      end
      tick;
    end
    tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL b2b_done2 got=%b exp=1", done_a); end
    tick;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_mid_frame;
    logic bad_done, bad_ser;
    bus_a.DIN = 8'h0B; bus_a.DIN_VALID = 1'b1;
    tick;
    bus_a.DIN_VALID = 1'b0;
    for (int c = 1; c < 18; c++) tick;
    tests++; if (ser_a !== 1'b1) begin fails++; $display("FAIL midrst_bit3 got=%b exp=1", ser_a); end
    clr_a = 1'b1;
    tick;
    tests++; if (ser_a !== 1'b1) begin fails++; $display("FAIL midrst_ser got=%b exp=1", ser_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL midrst_done got=%b exp=0", done_a); end
    tests++; if (bus_a.DIN_READY !== 1'b0) begin fails++; $display("FAIL midrst_ready_clr got=%b exp=0", bus_a.DIN_READY); end
    clr_a = 1'b0;
    #1;
    tests++; if (bus_a.DIN_READY !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", bus_a.DIN_READY); end
    bad_done = 1'b0; bad_ser = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done_a !== 1'b0) bad_done = 1'b1;
      if (ser_a !== 1'b1) bad_ser = 1'b1;
      tick;
    end
    tests++; if (bad_done !== 1'b0) begin fails++; $display("FAIL midrst_no_done got=%b exp=0", bad_done); end
    tests++; if (bad_ser !== 1'b0) begin fails++; $display("FAIL midrst_line_idle got=%b exp=0", bad_ser); end
  endtask

  task automatic test_stop2;
    bus_b.DIN = 5'h11; bus_b.DIN_VALID = 1'b1;
    tests++; if (bus_b.DIN_READY !== 1'b1) begin fails++; $display("FAIL stop2_ready got=%b exp=1", bus_b.DIN_READY); end
    tick;
    bus_b.DIN_VALID = 1'b0;
    for (int c = 1; c <= N_B; c++) begin
      tests++; if (ser_b !== pat_bit(PAT_11, 8, (c-1)/2)) begin fails++;
        $display("FAIL stop2_ser cyc=%0d got=%b exp=%b", c, ser_b, pat_bit(PAT_11, 8, (c-1)/2)); end
      tests++; if (done_b !== 1'b0) begin fails++; $display("FAIL stop2_done_early cyc=%0d got=%b exp=0", c, done_b); end
      tick;
    end
    tests++; if (done_b !== 1'b1) begin fails++; $display("FAIL stop2_done got=%b exp=1", done_b); end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL stop2_busy_end got=%b exp=0", busy_b); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity_odd;
    bus_c.DIN = 8'h0B; bus_c.DIN_VALID = 1'b1;
    tick;
    bus_c.DIN_VALID = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      tests++; if (ser_c !== pat_bit(PAT_0B_ODD, 11, (c-1)/4)) begin fails++;
        $display("FAIL odd_ser cyc=%0d got=%b exp=%b", c, ser_c, pat_bit(PAT_0B_ODD, 11, (c-1)/4)); end
      tests++; if (done_c !== 1'b0) begin fails++; $display("FAIL odd_done_early cyc=%0d got=%b exp=0", c, done_c); end
      tick;
    end
    tests++; if (done_c !== 1'b1) begin fails++; $display("FAIL odd_done got=%b exp=1", done_c); end
  endtask
`endif

  initial begin
`ifdef UART_TX_PARITY_EN
    clr_c = 1'b1; bus_c.DIN = 8'h00; bus_c.DIN_VALID = 1'b0;
`endif
    test_reset;
`ifdef UART_TX_PARITY_EN
    clr_c = 1'b0;
`endif
    test_basic_frame;
    test_busy_reject;
    test_back_to_back;
    test_reset_mid_frame;
    test_stop2;
`ifdef UART_TX_PARITY_EN
    test_parity_odd;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
